// File: rtl/tx_arbiter.sv
// tx_arbiter: two byte FIFOs (DMA side, memory hub side) arbitrated
// round-robin into a single UART transmitter launch interface.
//
// Ports:
//   clock, reset       : system clock, synchronous active-high reset
//   start0/data0/full0 : port 0 byte push, full flag
//   start1/data1/full1 : port 1 byte push, full flag
//   tx_start, sdata    : one-cycle launch pulse and held byte to transmit
//   tx_busy            : UART busy flag
//   overflow           : sticky per-port drop flags
//   idle               : both FIFOs empty and FSM idle
module tx_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start0,
    input  logic [7:0] data0,
    output logic       full0,
    input  logic       start1,
    input  logic [7:0] data1,
    output logic       full1,
    output logic       tx_start,
    output logic [7:0] sdata,
    input  logic       tx_busy,
    output logic [1:0] overflow,
    output logic       idle
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_HI,
        WAIT_LO
    } state_t;

    logic [7:0]    mem [2][DEPTH];
    logic [AW-1:0] wptr [2];
    logic [AW-1:0] rptr [2];
    logic [AW:0]   cnt [2];
    logic [7:0]    data_v [2];
    logic [1:0]    start_v;
    logic [1:0]    full_v;
    logic [1:0]    nempty;
    logic [1:0]    push;
    logic [1:0]    pop;

    state_t     state_q, state_d;
    logic [1:0] timer_q, timer_d;
    logic       last_q, last_d;
    logic       grant;
    logic       launch;
    logic       tx_start_d;
    logic [7:0] sdata_d;

    assign start_v   = {start1, start0};
    assign data_v[0] = data0;
    assign data_v[1] = data1;

    // DEPTH is a power of two, so the count MSB alone marks full.
    assign full_v[0] = cnt[0][AW];
    assign full_v[1] = cnt[1][AW];
    assign nempty[0] = |cnt[0];
    assign nempty[1] = |cnt[1];

    assign push = start_v & ~full_v;
    assign pop  = {launch & grant, launch & ~grant};

    assign full0 = full_v[0];
    assign full1 = full_v[1];
    assign idle  = ~|nempty && (state_q == IDLE);

    always_ff @(posedge clock) begin
        for (int n = 0; n < 2; n++) begin
            if (push[n]) begin
                mem[n][wptr[n]] <= data_v[n];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int n = 0; n < 2; n++) begin
                wptr[n] <= '0;
                rptr[n] <= '0;
                cnt[n]  <= '0;
            end
            overflow <= 2'b00;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (push[n]) begin
                    wptr[n] <= wptr[n] + 1'b1;
                end
                if (pop[n]) begin
                    rptr[n] <= rptr[n] + 1'b1;
                end
                if (push[n] && !pop[n]) begin
                    cnt[n] <= cnt[n] + 1'b1;
                end else if (!push[n] && pop[n]) begin
                    cnt[n] <= cnt[n] - 1'b1;
                end
                // full is registered, so a same-edge pop cannot save the byte
                if (start_v[n] && full_v[n]) begin
                    overflow[n] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        last_d     = last_q;
        sdata_d    = sdata;
        tx_start_d = 1'b0;
        launch     = 1'b0;
        if (nempty[0] && nempty[1]) begin
            grant = ~last_q;
        end else begin
            grant = nempty[1];
        end
        unique case (state_q)
            IDLE: begin
                if (!tx_busy && |nempty) begin
                    launch     = 1'b1;
                    tx_start_d = 1'b1;
                    sdata_d    = mem[grant][rptr[grant]];
                    last_d     = grant;
                    timer_d    = 2'd0;
                    state_d    = WAIT_HI;
                end
            end
            WAIT_HI: begin
                timer_d = timer_q + 2'd1;
                if (tx_busy || timer_q == 2'd3) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            timer_q  <= 2'd0;
            last_q   <= 1'b1;
            tx_start <= 1'b0;
            sdata    <= 8'h00;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            last_q   <= last_d;
            tx_start <= tx_start_d;
            sdata    <= sdata_d;
        end
    end

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning entries per input FIFO; legal values are powers of two, minimum 2.
REQ-002 SHALL have port clock, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port start0, input, 1, single-cycle byte request from the DMA controller side.
REQ-005 SHALL have port data0, input, 8, the byte qualified by start0.
REQ-006 SHALL have port full0, output, 1, high when FIFO0 holds DEPTH entries.
REQ-007 SHALL have port start1, input, 1, single-cycle byte request from the memory controller hub side.
REQ-008 SHALL have port data1, input, 8, the byte qualified by start1.
REQ-009 SHALL have port full1, output, 1, high when FIFO1 holds DEPTH entries.
REQ-010 SHALL have port tx_start, output, 1, one-cycle launch pulse to the UART transmitter.
REQ-011 SHALL have port sdata, output, 8, the byte to transmit, stable from the tx_start cycle until the next launch.
REQ-012 SHALL have port tx_busy, input, 1, the UART transmitter busy flag.
REQ-013 SHALL have port overflow, output, 2, sticky drop flags: bit0 for port 0, bit1 for port 1.
REQ-014 SHALL have port idle, output, 1, high when both FIFOs are empty and the FSM is in IDLE.

Function
REQ-015 SHALL push dataN into FIFO N on a rising edge where startN=1 and fullN=0; FIFO N SHALL be ordered first-in, first-out.
REQ-016 SHALL drop the byte when startN=1 and fullN=1, even if a pop of FIFO N occurs on the same edge, and SHALL set overflow[N]; overflow[N] SHALL stay set until reset.
REQ-017 SHALL apply a push and a pop of the same FIFO on the same edge together, leaving the count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-018 SHALL derive fullN and idle from registered counts and state only, with no combinational path from startN.
REQ-019 SHALL implement FSM states IDLE, WAIT_HI and WAIT_LO.
REQ-020 IDLE: if tx_busy=0 and at least one FIFO is non-empty, on the next edge the block SHALL pop the granted FIFO, register its head into sdata, set tx_start=1, load timer=0 and go to WAIT_HI.
REQ-021 Grant rule: if exactly one FIFO is non-empty, that FIFO SHALL be granted; if both are non-empty, the port not recorded in last_grant SHALL be granted; last_grant SHALL update on every launch.
REQ-022 WAIT_HI: tx_start SHALL be 0; the timer SHALL increment every cycle; on tx_busy=1, or when the timer reaches 3, the FSM SHALL go to WAIT_LO.
REQ-023 WAIT_LO: when tx_busy=0 the FSM SHALL go to IDLE; there is no timeout in this state.
REQ-024 tx_start SHALL be high for exactly one cycle per popped byte and SHALL never be high in two consecutive cycles.
REQ-025 Latency: a byte pushed into an empty FIFO on edge k, with the FSM in IDLE and tx_busy=0, SHALL produce tx_start=1 in the cycle following edge k+1.
REQ-026 While tx_busy=1 in IDLE, no launch SHALL occur and the FIFOs SHALL keep filling.

Reset
REQ-027 On reset=1 at a rising edge the block SHALL empty both FIFOs and set: tx_start=0, sdata=0x00, overflow=2'b00, full0=full1=0, idle=1, state=IDLE, timer=0, last_grant=1 (port 0 wins the first tie).
REQ-028 Reset SHALL take priority over simultaneous start0/start1, and SHALL abort any in-flight byte in WAIT_HI or WAIT_LO without a further tx_start.

Verification
REQ-029 Single byte: with tx_busy model rising 1 cycle after tx_start and falling 20 cycles later, start0 with data0=0x41 -> one tx_start with sdata=0x41 two edges later; idle=1 after busy falls.
REQ-030 Fairness: push 0x10,0x11 to port 0 and 0xA0,0xA1 to port 1 on the same edges -> transmit order 0x10,0xA0,0x11,0xA1.
REQ-031 Overflow: with DEPTH=4 and tx_busy held 1, push 5 bytes on port 0 -> full0=1 after the 4th push; overflow=2'b01; release busy -> exactly 4 bytes sent in order.
REQ-032 Timeout: tx_busy tied 0 with 3 bytes queued on port 1 -> 3 tx_start pulses, each WAIT_HI lasting 4 cycles, none adjacent.
REQ-033 Reset mid-operation: assert reset while in WAIT_LO with 2 bytes queued -> next cycle idle=1, tx_start=0, sdata=0x00; no further pulses after busy falls.
